// File: rtl/fifo_chain.sv
// fifo_chain: NSTAGES cascaded circular-buffer FIFO stages forming one
// in-order queue. Words enter stage 0 and leave from stage NSTAGES-1.
// Between stages, words move either automatically or only when the
// matching advance bit is set, depending on mode. The block also reports
// total occupancy and sticky overflow/underflow flags.
module fifo_chain #(
   parameter int WIDTH       = 8,
   parameter int STAGE_DEPTH = 4,
   parameter int NSTAGES     = 2
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        push,
   input  logic [WIDTH-1:0]                            data_in,
   input  logic                                        pop,
   input  logic                                        mode,
   input  logic [NSTAGES-2:0]                          advance,
   output logic [NSTAGES-1:0]                          empty,
   output logic [NSTAGES-1:0]                          full,
   output logic [WIDTH-1:0]                            data_out,
   output logic                                        data_out_vld,
   output logic [$clog2(NSTAGES*STAGE_DEPTH+1)-1:0]    count,
   output logic                                        overflow,
   output logic                                        underflow
);

   localparam int PW = $clog2(STAGE_DEPTH);
   localparam int OW = PW + 1;
   localparam int CW = $clog2(NSTAGES*STAGE_DEPTH+1);

   // Per-stage enqueue/dequeue strobes and the data word entering each stage
   logic [NSTAGES-1:0] enq;
   logic [NSTAGES-1:0] deq;
   logic [WIDTH-1:0]   enq_data  [NSTAGES];
   logic [WIDTH-1:0]   head_data [NSTAGES];
   logic [NSTAGES-2:0] xfer;
   logic               push_acc;
   logic               pop_acc;

   // Accept decisions use only the registered flags, so a full stage never
   // accepts and an empty stage never sends within the same cycle
   assign push_acc = push & ~full[0];
   assign pop_acc  = pop & ~empty[NSTAGES-1];

   genvar g;
   generate
      for (g = 0; g < NSTAGES; g++) begin : g_stage
         logic [WIDTH-1:0] mem [STAGE_DEPTH];
         logic [PW-1:0]    rd_ptr;
         logic [PW-1:0]    wr_ptr;
         logic [OW-1:0]    occ;
         logic [OW-1:0]    occ_next;
         logic             st_empty;
         logic             st_full;

         // Stage 0 is fed by the producer; later stages by the previous head
         if (g == 0) begin : g_first
            assign enq[g]      = push_acc;
            assign enq_data[g] = data_in;
         end else begin : g_link
            assign enq[g]      = xfer[g-1];
            assign enq_data[g] = head_data[g-1];
         end

         // The last stage drains to the consumer; others hand off downstream
         if (g == NSTAGES-1) begin : g_last
            assign deq[g] = pop_acc;
         end else begin : g_xfer
            assign xfer[g] = (mode ? advance[g] : 1'b1) & ~st_empty & ~full[g+1];
            assign deq[g]  = xfer[g];
         end

         assign head_data[g] = mem[rd_ptr];
         assign occ_next     = occ + OW'(enq[g]) - OW'(deq[g]);
         assign empty[g]     = st_empty;
         assign full[g]      = st_full;

         // Storage array; contents after reset are irrelevant so it has no reset
         always_ff @(posedge clk) begin
            if (enq[g]) begin
               mem[wr_ptr] <= enq_data[g];
            end
         end

         // Pointers, occupancy and registered flags for this stage
         always_ff @(posedge clk) begin
            if (!rst) begin
               rd_ptr   <= '0;
               wr_ptr   <= '0;
               occ      <= '0;
               st_empty <= 1'b1;
               st_full  <= 1'b0;
            end else begin
               if (enq[g]) begin
                  wr_ptr <= wr_ptr + PW'(1);
               end
               if (deq[g]) begin
                  rd_ptr <= rd_ptr + PW'(1);
               end
               occ      <= occ_next;
               st_empty <= (occ_next == '0);
               st_full  <= (occ_next == OW'(STAGE_DEPTH));
            end
         end
      end
   endgenerate

   assign data_out     = empty[NSTAGES-1] ? '0 : head_data[NSTAGES-1];
   assign data_out_vld = ~empty[NSTAGES-1];

   // Total occupancy only moves at the chain boundaries; sticky error flags
   always_ff @(posedge clk) begin
      if (!rst) begin
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         count     <= count + CW'(push_acc) - CW'(pop_acc);
         overflow  <= overflow | (push & full[0]);
         underflow <= underflow | (pop & empty[NSTAGES-1]);
      end
   end

endmodule

// File: tb/tb_fifo_chain.sv
// tb_fifo_chain: directed bench for the default fifo_chain configuration
// (8-bit words, two stages of four entries).
module tb_fifo_chain;

   logic       clk = 1'b0;
   logic       rst;
   logic       push;
   logic [7:0] data_in;
   logic       pop;
   logic       mode;
   logic [0:0] advance;
   logic [1:0] empty;
   logic [1:0] full;
   logic [7:0] data_out;
   logic       data_out_vld;
   logic [3:0] count;
   logic       overflow;
   logic       underflow;

   int total = 0;
   int bad   = 0;

   fifo_chain #(.WIDTH(8), .STAGE_DEPTH(4), .NSTAGES(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .push         (push),
      .data_in      (data_in),
      .pop          (pop),
      .mode         (mode),
      .advance      (advance),
      .empty        (empty),
      .full         (full),
      .data_out     (data_out),
      .data_out_vld (data_out_vld),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Last-resort guard so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance one clock edge and settle just after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst     = 1'b0;
      push    = 1'b0;
      pop     = 1'b0;
      mode    = 1'b0;
      advance = 1'b0;
      data_in = 8'h00;
      step();
      step();
      rst = 1'b1;
   endtask

   // Reset while pushing must store nothing and leave everything cleared
   task automatic test_reset();
      rst     = 1'b0;
      push    = 1'b1;
      data_in = 8'hAA;
      pop     = 1'b0;
      mode    = 1'b0;
      advance = 1'b0;
      step();
      step();
      rst  = 1'b1;
      push = 1'b0;
      step();
      step();
      total++; if (empty !== 2'b11) begin bad++; $display("[TB] FAIL reset_empty: got %b want 11", empty); end
      total++; if (full !== 2'b00) begin bad++; $display("[TB] FAIL reset_full: got %b want 00", full); end
      total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
      total++; if (data_out_vld !== 1'b0) begin bad++; $display("[TB] FAIL reset_vld: got %b want 0", data_out_vld); end
      total++; if (data_out !== 8'h00) begin bad++; $display("[TB] FAIL reset_data: got %h want 00", data_out); end
      total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("[TB] FAIL reset_flags: got %b want 00", {overflow, underflow}); end
   endtask

   // Three pushes in auto mode, two-cycle latency to the output, then drain
   task automatic test_auto_basic();
      do_reset();
      push = 1'b1; data_in = 8'h11;
      step();
      total++; if (data_out_vld !== 1'b0) begin bad++; $display("[TB] FAIL basic_vld_early: got %b want 0", data_out_vld); end
      data_in = 8'h22;
      step();
      total++; if (data_out_vld !== 1'b1) begin bad++; $display("[TB] FAIL basic_vld_rise: got %b want 1", data_out_vld); end
      total++; if (data_out !== 8'h11) begin bad++; $display("[TB] FAIL basic_head: got %h want 11", data_out); end
      data_in = 8'h33;
      step();
      push = 1'b0;
      total++; if (count !== 4'd3) begin bad++; $display("[TB] FAIL basic_count3: got %0d want 3", count); end
      step();
      total++; if (empty !== 2'b01) begin bad++; $display("[TB] FAIL basic_empty_settled: got %b want 01", empty); end
      pop = 1'b1;
      step();
      total++; if (data_out !== 8'h22) begin bad++; $display("[TB] FAIL basic_pop1: got %h want 22", data_out); end
      total++; if (count !== 4'd2) begin bad++; $display("[TB] FAIL basic_count2: got %0d want 2", count); end
      step();
      total++; if (data_out !== 8'h33) begin bad++; $display("[TB] FAIL basic_pop2: got %h want 33", data_out); end
      step();
      pop = 1'b0;
      total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL basic_count0: got %0d want 0", count); end
      total++; if (data_out_vld !== 1'b0) begin bad++; $display("[TB] FAIL basic_vld_fall: got %b want 0", data_out_vld); end
      total++; if (data_out !== 8'h00) begin bad++; $display("[TB] FAIL basic_data_masked: got %h want 00", data_out); end
      total++; if (underflow !== 1'b0) begin bad++; $display("[TB] FAIL basic_no_underflow: got %b want 0", underflow); end
   endtask

   // Fill all eight entries, overflow on the ninth push, drain in order
   task automatic test_auto_full();
      do_reset();
      for (int k = 1; k <= 8; k++) begin
         push = 1'b1; data_in = 8'(k);
         step();
      end
      total++; if (full !== 2'b11) begin bad++; $display("[TB] FAIL full_flags: got %b want 11", full); end
      total++; if (count !== 4'd8) begin bad++; $display("[TB] FAIL full_count8: got %0d want 8", count); end
      total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL full_no_overflow_yet: got %b want 0", overflow); end
      data_in = 8'h09;
      step();
      push = 1'b0;
      total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL full_overflow: got %b want 1", overflow); end
      total++; if (count !== 4'd8) begin bad++; $display("[TB] FAIL full_count_hold: got %0d want 8", count); end
      pop = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         total++; if (data_out !== 8'(k) || data_out_vld !== 1'b1) begin
            bad++; $display("[TB] FAIL full_drain_%0d: got %h vld %b want %h vld 1", k, data_out, data_out_vld, 8'(k));
         end
         step();
      end
      pop = 1'b0;
      total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL full_drain_count: got %0d want 0", count); end
      total++; if (empty !== 2'b11) begin bad++; $display("[TB] FAIL full_drain_empty: got %b want 11", empty); end
      total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL full_overflow_sticky: got %b want 1", overflow); end
   endtask

   // Manual mode holds words in stage 0 until advance is asserted
   task automatic test_manual();
      do_reset();
      mode = 1'b1;
      for (int k = 0; k < 4; k++) begin
         push = 1'b1; data_in = 8'h41 + 8'(k);
         step();
      end
      push = 1'b0;
      total++; if (empty !== 2'b10) begin bad++; $display("[TB] FAIL manual_empty_hold: got %b want 10", empty); end
      total++; if (full !== 2'b01) begin bad++; $display("[TB] FAIL manual_full_hold: got %b want 01", full); end
      total++; if (data_out_vld !== 1'b0) begin bad++; $display("[TB] FAIL manual_vld_hold: got %b want 0", data_out_vld); end
      advance = 1'b1;
      step();
      step();
      advance = 1'b0;
      step();
      total++; if (count !== 4'd4) begin bad++; $display("[TB] FAIL manual_count: got %0d want 4", count); end
      total++; if (data_out !== 8'h41) begin bad++; $display("[TB] FAIL manual_head: got %h want 41", data_out); end
      total++; if ({full, empty} !== 4'b0000) begin bad++; $display("[TB] FAIL manual_split_flags: got full %b empty %b want 00 00", full, empty); end
      mode = 1'b0;
      pop  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         total++; if (data_out !== 8'h41 + 8'(k)) begin
            bad++; $display("[TB] FAIL manual_drain_%0d: got %h want %h", k, data_out, 8'h41 + 8'(k));
         end
         step();
      end
      pop = 1'b0;
      total++; if (empty !== 2'b11) begin bad++; $display("[TB] FAIL manual_drain_empty: got %b want 11", empty); end
   endtask

   // Underflow on an empty chain, then a 20-word stream wrapping the pointers
   task automatic test_underflow_wrap();
      int pushed;
      int popped;
      do_reset();
      pop = 1'b1;
      step();
      pop = 1'b0;
      total++; if (underflow !== 1'b1) begin bad++; $display("[TB] FAIL wrap_underflow: got %b want 1", underflow); end
      total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL wrap_underflow_count: got %0d want 0", count); end
      pushed = 0;
      popped = 0;
      for (int cyc = 0; cyc < 60 && popped < 20; cyc++) begin
         push    = (pushed < 20);
         data_in = 8'h80 + 8'(pushed);
         pop     = data_out_vld;
         if (data_out_vld) begin
            total++; if (data_out !== 8'h80 + 8'(popped)) begin
               bad++; $display("[TB] FAIL wrap_order_%0d: got %h want %h", popped, data_out, 8'h80 + 8'(popped));
            end
            popped++;
         end
         if (push) pushed++;
         step();
         total++; if (full !== 2'b00) begin bad++; $display("[TB] FAIL wrap_full_cyc%0d: got %b want 00", cyc, full); end
      end
      push = 1'b0;
      pop  = 1'b0;
      total++; if (popped !== 20) begin bad++; $display("[TB] FAIL wrap_popped: got %0d want 20", popped); end
      total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL wrap_count_end: got %0d want 0", count); end
      total++; if (underflow !== 1'b1) begin bad++; $display("[TB] FAIL wrap_underflow_sticky: got %b want 1", underflow); end
      rst = 1'b0;
      step();
      rst = 1'b1;
      total++; if (underflow !== 1'b0) begin bad++; $display("[TB] FAIL wrap_underflow_cleared: got %b want 0", underflow); end
   endtask

   // Run every scenario in order, then report
   initial begin
      $display("[TB] starting fifo_chain bench");
      test_reset();
      test_auto_basic();
      test_auto_full();
      test_manual();
      test_underflow_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
